// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction loader: state codes and parameter defaults.
package instr_loader_pkg;

  localparam int unsigned DATA_WIDTH_DEF     = 32;
  localparam int unsigned RELEASE_CYCLES_DEF = 2;
  localparam int unsigned HOLD_CTR_W         = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_RUN  = 2'd3;

endpackage

// File: rtl/instr_loader_if.sv
// Loader control, word-stream and instruction-memory signals bundled as one interface.
interface instr_loader_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                  Start;
  logic [ADDR_WIDTH:0]   Load_Len;
  logic                  In_Valid;
  logic [DATA_WIDTH-1:0] In_Data;
  logic                  In_Ready;
  logic                  Imem_We;
  logic [ADDR_WIDTH-1:0] Imem_Addr;
  logic [DATA_WIDTH-1:0] Imem_Wdata;
  logic                  Cpu_Reset;
  logic                  Done;
  logic                  Err;

  modport master (
    output Start, Load_Len, In_Valid, In_Data,
    input  In_Ready, Imem_We, Imem_Addr, Imem_Wdata, Cpu_Reset, Done, Err
  );

  modport slave (
    input  Start, Load_Len, In_Valid, In_Data,
    output In_Ready, Imem_We, Imem_Addr, Imem_Wdata, Cpu_Reset, Done, Err
  );

endinterface

// File: rtl/instr_loader_hold_ctr.sv
// Loadable down-counter that times how long the processor stays held after the last write.
module instr_loader_hold_ctr #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             tc_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/instr_loader.sv
// Streams a program image into instruction memory, holding the processor in reset
// until the final write has settled, then releases it.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int unsigned RELEASE_CYCLES = RELEASE_CYCLES_DEF
) (
  input logic           Clk,
  input logic           Reset,
  instr_loader_if.slave bus
);

  localparam logic [ADDR_WIDTH:0]   DEPTH     = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   IDX_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [HOLD_CTR_W-1:0] HOLD_INIT = HOLD_CTR_W'(RELEASE_CYCLES - 1);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH:0]   idx_q, idx_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  cpu_rst_q, cpu_rst_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic xfer, last, len_ok, hold_load, hold_tc;

  assign xfer   = (state_q == ST_LOAD) && bus.In_Valid;
  assign last   = xfer && (idx_q == (len_q - IDX_ONE));
  assign len_ok = (bus.Load_Len != '0) && (bus.Load_Len <= DEPTH);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    we_d      = xfer;
    addr_d    = xfer ? idx_q[ADDR_WIDTH-1:0] : addr_q;
    wdata_d   = xfer ? bus.In_Data : wdata_q;
    cpu_rst_d = cpu_rst_q;
    done_d    = done_q;
    err_d     = err_q;
    hold_load = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cpu_rst_d = 1'b1;
        done_d    = 1'b0;
        if (bus.Start) begin
          if (len_ok) begin
            len_d   = bus.Load_Len;
            idx_d   = '0;
            err_d   = 1'b0;
            state_d = ST_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          idx_d = last ? '0 : (idx_q + IDX_ONE);
        end
        // The final word goes out on the same edge that enters HOLD, so the
        // hold count starts with that write.
        if (last) begin
          hold_load = 1'b1;
          state_d   = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (hold_tc) begin
          cpu_rst_d = 1'b0;
          done_d    = 1'b1;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.Start) begin
          if (len_ok) begin
            len_d     = bus.Load_Len;
            idx_d     = '0;
            err_d     = 1'b0;
            cpu_rst_d = 1'b1;
            done_d    = 1'b0;
            state_d   = ST_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      len_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  instr_loader_hold_ctr #(
    .WIDTH (HOLD_CTR_W)
  ) u_hold_ctr (
    .clk        (Clk),
    .rst        (Reset),
    .load_i     (hold_load),
    .load_val_i (HOLD_INIT),
    .dec_i      (state_q == ST_HOLD),
    .tc_o       (hold_tc)
  );

  assign bus.In_Ready   = (state_q == ST_LOAD);
  assign bus.Imem_We    = we_q;
  assign bus.Imem_Addr  = addr_q;
  assign bus.Imem_Wdata = wdata_q;
  assign bus.Cpu_Reset  = cpu_rst_q;
  assign bus.Done       = done_q;
  assign bus.Err        = err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: expected memory writes are queued when words are
// offered and matched against Imem_* one cycle later.
module tb_instr_loader;

  localparam int unsigned AW  = 8;
  localparam int unsigned DW  = 32;
  localparam int unsigned REL = 2;

  typedef struct {
    int          cyc;
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic Clk;
  logic Reset;
  int   n_vec;
  int   n_err;
  int   cyc;
  wr_t  sb[$];
  logic [31:0] prog [4];

  instr_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  instr_loader #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .RELEASE_CYCLES (REL)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mon();
    wr_t e;
    if (Reset) return;
    if (bus.Imem_We === 1'b1) begin
      if (sb.size() == 0) begin
        check("extra_we", bus.Imem_We, 1'b0);
      end else begin
        e = sb.pop_front();
        check("wr_cyc", cyc, e.cyc);
        check("wr_addr", bus.Imem_Addr, e.addr);
        check("wr_data", bus.Imem_Wdata, e.data);
      end
    end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      check("missing_we", bus.Imem_We, 1'b1);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
    cyc++;
    mon();
  endtask

  task automatic do_start(input logic [8:0] len);
    bus.Start    = 1'b1;
    bus.Load_Len = len;
    step();
    bus.Start = 1'b0;
  endtask

  task automatic put_word(input logic [31:0] d, input logic [7:0] a);
    bus.In_Valid = 1'b1;
    bus.In_Data  = d;
    check("in_ready", bus.In_Ready, 1'b1);
    sb.push_back('{cyc + 1, a, d});
    step();
  endtask

  task automatic finish_load();
    bus.In_Valid = 1'b0;
    bus.Start    = 1'b0;
    check("hold_ready", bus.In_Ready, 1'b0);
    check("hold_cpurst_a", bus.Cpu_Reset, 1'b1);
    check("hold_done_a", bus.Done, 1'b0);
    step();
    check("hold_cpurst_b", bus.Cpu_Reset, 1'b1);
    check("hold_done_b", bus.Done, 1'b0);
    step();
    check("run_cpurst", bus.Cpu_Reset, 1'b0);
    check("run_done", bus.Done, 1'b1);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    prog  = '{32'h20080005, 32'h20090003, 32'h01095020, 32'hAC0A0000};
    Reset        = 1'b1;
    bus.Start    = 1'b0;
    bus.Load_Len = '0;
    bus.In_Valid = 1'b0;
    bus.In_Data  = '0;

    #2;
    check("rst_cpurst", bus.Cpu_Reset, 1'b1);
    check("rst_ready", bus.In_Ready, 1'b0);
    check("rst_we", bus.Imem_We, 1'b0);
    check("rst_done", bus.Done, 1'b0);
    check("rst_err", bus.Err, 1'b0);
    check("rst_addr", bus.Imem_Addr, 8'h00);
    check("rst_wdata", bus.Imem_Wdata, 32'h0);
    step();
    step();
    Reset = 1'b0;
    step();

    // illegal lengths in IDLE
    do_start(9'd0);
    check("err_len0", bus.Err, 1'b1);
    check("err_len0_ready", bus.In_Ready, 1'b0);
    check("err_len0_cpurst", bus.Cpu_Reset, 1'b1);
    do_start(9'd257);
    check("err_len257", bus.Err, 1'b1);
    check("err_len257_ready", bus.In_Ready, 1'b0);

    // back-to-back load of 4 words; a Start alongside the last word must be ignored
    do_start(9'd4);
    check("err_cleared", bus.Err, 1'b0);
    check("load_ready", bus.In_Ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        bus.Start    = 1'b1;
        bus.Load_Len = 9'd1;
      end
      put_word(prog[i], 8'(i));
    end
    finish_load();

    // illegal Start in RUN leaves processor running
    do_start(9'd0);
    check("run_err", bus.Err, 1'b1);
    check("run_err_cpurst", bus.Cpu_Reset, 1'b0);
    check("run_err_done", bus.Done, 1'b1);
    check("run_err_ready", bus.In_Ready, 1'b0);

    // reload from RUN with gaps between words and a Start during LOAD
    do_start(9'd4);
    check("reload_cpurst", bus.Cpu_Reset, 1'b1);
    check("reload_done", bus.Done, 1'b0);
    check("reload_err", bus.Err, 1'b0);
    for (int i = 0; i < 4; i++) begin
      put_word(prog[i], 8'(i));
      if (i < 3) begin
        bus.In_Valid = 1'b0;
        if (i == 1) begin
          bus.Start    = 1'b1;
          bus.Load_Len = 9'd1;
        end
        step();
        bus.Start = 1'b0;
      end
    end
    finish_load();

    // asynchronous reset after 2 of 4 words
    do_start(9'd4);
    put_word(32'hDEAD0001, 8'h00);
    put_word(32'hDEAD0002, 8'h01);
    bus.In_Valid = 1'b0;
    @(negedge Clk);
    #1;
    Reset = 1'b1;
    #1;
    check("arst_we", bus.Imem_We, 1'b0);
    check("arst_ready", bus.In_Ready, 1'b0);
    check("arst_done", bus.Done, 1'b0);
    check("arst_cpurst", bus.Cpu_Reset, 1'b1);
    check("arst_addr", bus.Imem_Addr, 8'h00);
    step();
    Reset = 1'b0;
    step();
    check("post_arst_ready", bus.In_Ready, 1'b0);
    do_start(9'd4);
    for (int i = 0; i < 4; i++) put_word(prog[3 - i], 8'(i));
    finish_load();

    // single-word reload from RUN
    do_start(9'd1);
    check("len1_cpurst", bus.Cpu_Reset, 1'b1);
    check("len1_done", bus.Done, 1'b0);
    put_word(32'h0BADF00D, 8'h00);
    finish_load();

    // full-depth load
    do_start(9'd256);
    for (int i = 0; i < 256; i++) put_word($urandom, 8'(i));
    finish_load();
    check("full_last_addr", bus.Imem_Addr, 8'hFF);
    for (int i = 0; i < 4; i++) step();
    check("full_ready_idle", bus.In_Ready, 1'b0);
    check("full_done_hold", bus.Done, 1'b1);
    check("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Front-end stage that sits directly upstream of Main_Processor and owns its reset.
- After system reset or a Start request, it streams a program image into instruction memory over a valid/ready word interface.
- While loading, it holds the processor in reset. Once the last word is written and a programmable settle delay has passed, it releases the processor reset.
- Replaces free-running bench reset pulses with a deterministic load-then-run sequence.

Parameters:
- ADDR_WIDTH, 8, instruction-memory word-address width; depth = 2^ADDR_WIDTH words.
- DATA_WIDTH, 32, instruction word width.
- RELEASE_CYCLES, 2, cycles Cpu_Reset stays high after the last memory write (range 1..15).

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  single-cycle request to begin a load.
- Load_Len  in  ADDR_WIDTH+1  number of words to load; sampled only on an accepted Start.
- In_Valid  in  1  source word valid.
- In_Data  in  DATA_WIDTH  source instruction word.
- In_Ready  out  1  loader can accept a word this cycle.
- Imem_We  out  1  instruction-memory write enable.
- Imem_Addr  out  ADDR_WIDTH  instruction-memory word address.
- Imem_Wdata  out  DATA_WIDTH  instruction-memory write data.
- Cpu_Reset  out  1  reset to Main_Processor; high = processor held.
- Done  out  1  program loaded and processor running.
- Err  out  1  sticky flag: last Start carried an illegal Load_Len.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-load or mid-run):
  - state = IDLE.
  - Cpu_Reset = 1.
  - In_Ready, Imem_We, Done, Err = 0.
  - Imem_Addr, Imem_Wdata = 0.
  - word count and hold count cleared.
- All outputs are registered except In_Ready, which is decoded from state only (In_Ready = state==LOAD). In_Ready never depends on In_Valid.
- States: IDLE, LOAD, HOLD, RUN.
- IDLE:
  - Cpu_Reset = 1, Done = 0.
  - Start with 1 <= Load_Len <= 2^ADDR_WIDTH: latch Load_Len, clear Err, word index = 0, next state LOAD.
  - Start with Load_Len = 0 or Load_Len > 2^ADDR_WIDTH: Err = 1, stay IDLE.
- LOAD:
  - A transfer occurs on any cycle with In_Valid && In_Ready.
  - On the next edge after a transfer: Imem_We = 1, Imem_Addr = current index, Imem_Wdata = In_Data; index increments. Write latency is 1 cycle.
  - Cycles with no transfer: Imem_We = 0 on the next edge. Addr/data hold their last values.
  - Transfer of word Load_Len-1: next state HOLD; In_Ready drops the following cycle. That final word is written in the first HOLD cycle.
  - Start is ignored in LOAD.
- HOLD:
  - Cpu_Reset stays 1 for RELEASE_CYCLES cycles counted from the edge that performs the last write.
  - Then next state RUN.
  - Start is ignored in HOLD.
- RUN:
  - Cpu_Reset = 0, Done = 1, registered and changing on the same edge.
  - Start with a legal length: Cpu_Reset = 1 and Done = 0 on the next edge, index = 0, next state LOAD.
  - Start with an illegal length: Err = 1, stay RUN, processor undisturbed.
- Address and count rules:
  - Load_Len = 2^ADDR_WIDTH fills memory fully.
  - The index wraps to 0 after the final write. This wrap is never used for a further write.
  - The index counter is ADDR_WIDTH+1 bits so that full-depth completion can be detected.
- Simultaneous events: Reset wins over everything. Start arriving on the same edge as the LOAD→HOLD transition is ignored.
- Cpu_Reset is never low while Imem_We can still be asserted.

Decomposition:
- Shared package holds:
  - loader state enumeration (IDLE=2'd0, LOAD=2'd1, HOLD=2'd2, RUN=2'd3);
  - DATA_WIDTH default;
  - RELEASE_CYCLES default.
- One natural sub-module, instr_loader_hold_ctr: a down-counter with load/terminal-count used for the HOLD delay.
- Word indexing stays inline.

Test Plan:
- Reset then Start with Load_Len=4; words 0x20080005, 0x20090003, 0x01095020, 0xAC0A0000 with In_Valid held high -> Imem_We high 4 consecutive cycles at addr 0..3 with matching data; Cpu_Reset falls exactly RELEASE_CYCLES=2 cycles after the addr-3 write; Done=1 on the same edge.
- Same load with In_Valid low every other cycle -> writes occur only one cycle after each handshake; addresses stay contiguous 0..3; no extra Imem_We pulses.
- Start with Load_Len=0, then Start with Load_Len=257 (ADDR_WIDTH=8) -> Err=1, state stays IDLE, Cpu_Reset=1; a following legal Start clears Err.
- Assert Reset asynchronously mid-LOAD after 2 of 4 words -> Imem_We, In_Ready and Done drop immediately, Cpu_Reset=1; a new Start reloads from addr 0.
- In RUN, pulse Start with Load_Len=1 -> Cpu_Reset=1 and Done=0 on the next edge; one word is written to addr 0; the processor is released again after 2 cycles.
- Load_Len=256 -> final write at addr 0xFF, no write to addr 0 afterwards, then HOLD→RUN.
